// File: rtl/tcp_session_ctl.sv
// Session command sequencer for the TCP stack control/status interface.
// Issues one stack strobe per command and tracks status until done, fail or timeout, with retries.
module tcp_session_ctl #(
  parameter int unsigned TIMEOUT_TICKS = 125000000,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned TMR_W         = 32,
  parameter int unsigned RTY_W         = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_val,
  input  logic [1:0]       cmd_op,
  output logic             cmd_rdy,
  output logic             tcp_connect_addr,
  output logic             tcp_connect_name,
  output logic             tcp_listen,
  output logic             tcp_disconnect,
  input  logic             tcp_status_idle,
  input  logic             tcp_status_wait_dns,
  input  logic             tcp_status_listening,
  input  logic             tcp_status_connecting,
  input  logic             tcp_status_connected,
  input  logic             tcp_status_disconnecting,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [RTY_W-1:0] retry_cnt
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StAbort, StAbortWait} state_e;

  localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT_TICKS - 1);
  localparam logic [RTY_W-1:0] RtyMax  = RTY_W'(MAX_RETRY);
  localparam logic [3:0]       StrbDisc = 4'b1000;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic             left_idle_q, left_idle_d;
  logic [3:0]       strb_q, strb_d;  // {disconnect, listen, connect_name, connect_addr}
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             busy_q, busy_d;
  logic             cmd_rdy_q, cmd_rdy_d;

  logic op_ok, stack_active, timeout;

  // Status lines are one-hot, so any non-idle line means the stack has left idle.
  assign stack_active = tcp_status_wait_dns | tcp_status_listening | tcp_status_connecting |
                        tcp_status_connected | tcp_status_disconnecting;
  assign timeout      = (tmr_q == TmrLast);

  always_comb begin
    unique case (op_q)
      2'd0, 2'd1: op_ok = tcp_status_connected;
      2'd2:       op_ok = tcp_status_listening;
      default:    op_ok = tcp_status_idle;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    tmr_d       = tmr_q;
    rty_d       = rty_q;
    left_idle_d = left_idle_q;
    strb_d      = '0;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    busy_d      = busy_q;
    cmd_rdy_d   = cmd_rdy_q;

    case (state_q)
      StIdle: begin
        if (cmd_val && cmd_rdy_q) begin
          op_d  = cmd_op;
          rty_d = '0;
          if (cmd_op != 2'd3 && !tcp_status_idle) begin
            fail_d = 1'b1;
          end else begin
            strb_d    = 4'b0001 << cmd_op;
            state_d   = StIssue;
            busy_d    = 1'b1;
            cmd_rdy_d = 1'b0;
          end
        end
      end
      StIssue: begin
        tmr_d       = '0;
        left_idle_d = 1'b0;
        state_d     = StWait;
      end
      StWait: begin
        tmr_d = tmr_q + 1'b1;
        if (stack_active) left_idle_d = 1'b1;
        if (op_ok) begin
          done_d    = 1'b1;
          state_d   = StIdle;
          busy_d    = 1'b0;
          cmd_rdy_d = 1'b1;
        end else if (op_q == 2'd3) begin
          if (timeout) begin
            fail_d    = 1'b1;
            state_d   = StIdle;
            busy_d    = 1'b0;
            cmd_rdy_d = 1'b1;
          end
        end else if ((tcp_status_idle && left_idle_q) || timeout) begin
          strb_d  = StrbDisc;
          state_d = StAbort;
        end
      end
      StAbort: begin
        tmr_d   = '0;
        state_d = StAbortWait;
      end
      StAbortWait: begin
        tmr_d = tmr_q + 1'b1;
        if (tcp_status_idle && rty_q < RtyMax) begin
          rty_d   = rty_q + 1'b1;
          strb_d  = 4'b0001 << op_q;
          state_d = StIssue;
        end else if (tcp_status_idle || timeout) begin
          fail_d    = 1'b1;
          state_d   = StIdle;
          busy_d    = 1'b0;
          cmd_rdy_d = 1'b1;
        end
      end
      default: begin
        state_d   = StIdle;
        busy_d    = 1'b0;
        cmd_rdy_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= 2'd0;
      tmr_q       <= '0;
      rty_q       <= '0;
      left_idle_q <= 1'b0;
      strb_q      <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_rdy_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      tmr_q       <= tmr_d;
      rty_q       <= rty_d;
      left_idle_q <= left_idle_d;
      strb_q      <= strb_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      busy_q      <= busy_d;
      cmd_rdy_q   <= cmd_rdy_d;
    end
  end

  assign tcp_connect_addr = strb_q[0];
  assign tcp_connect_name = strb_q[1];
  assign tcp_listen       = strb_q[2];
  assign tcp_disconnect   = strb_q[3];
  assign done             = done_q;
  assign fail             = fail_q;
  assign busy             = busy_q;
  assign cmd_rdy          = cmd_rdy_q;
  assign retry_cnt        = rty_q;

endmodule

// File: doc/tcp_session_ctl.md
Name: tcp_session_ctl

Overview:
Command sequencer placed between user logic and the TCP control/status interface of the network stack top level. It accepts one high-level session command at a time: connect by address, connect by name, listen, or disconnect. It pulses the matching stack strobe, then watches the stack's one-hot status lines until the command succeeds, fails or times out. Failed connect/listen attempts are torn down and retried up to a bounded count.

Parameters:
TIMEOUT_TICKS, 125000000, per-attempt timeout in clk cycles (1 s at 125 MHz); also the limit on the abort wait.
MAX_RETRY, 3, retries after the first failed attempt (connect/listen only).
TMR_W, 32, timer width; must hold TIMEOUT_TICKS-1.
RTY_W, 2, retry counter width; must hold MAX_RETRY.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cmd_val  in  1  command valid
cmd_op  in  2  0=connect_addr, 1=connect_name, 2=listen, 3=disconnect
cmd_rdy  out  1  command can be accepted
tcp_connect_addr  out  1  one-cycle strobe to stack
tcp_connect_name  out  1  one-cycle strobe to stack
tcp_listen  out  1  one-cycle strobe to stack
tcp_disconnect  out  1  one-cycle strobe to stack
tcp_status_idle  in  1  stack status; all status inputs one-hot
tcp_status_wait_dns  in  1  stack status
tcp_status_listening  in  1  stack status
tcp_status_connecting  in  1  stack status
tcp_status_connected  in  1  stack status
tcp_status_disconnecting  in  1  stack status
busy  out  1  command in progress
done  out  1  one-cycle success pulse
fail  out  1  one-cycle final-failure pulse
retry_cnt  out  RTY_W  retries consumed by the current or last command

Behaviour:
- All outputs registered. Reset values: every strobe 0, done 0, fail 0, busy 0, retry_cnt 0, cmd_rdy 1. State = IDLE.
- States: IDLE, ISSUE, WAIT, ABORT, ABORT_WAIT.
- IDLE: cmd_rdy=1, busy=0.
  - Accept when cmd_val & cmd_rdy in cycle N: latch op, clear retry_cnt, go to ISSUE. cmd_rdy=0 and busy=1 from N+1.
  - Connect or listen accepted while tcp_status_idle=0: no strobe; fail pulses in N+1; return to IDLE.
  - cmd_val while busy is ignored; it is not queued.
- ISSUE: exactly one strobe is high for one cycle (op mapping: 0→connect_addr, 1→connect_name, 2→listen, 3→disconnect). Strobe appears in cycle N+1 after acceptance. Clear timer and left_idle flag; go to WAIT.
- WAIT: timer increments every cycle. Set left_idle when tcp_status_idle=0. Success and failure conditions per op:
  - connect (0/1): success on tcp_status_connected. Failure on tcp_status_idle with left_idle=1. wait_dns and connecting are treated as progress.
  - listen: success on tcp_status_listening. Failure on tcp_status_idle with left_idle=1.
  - disconnect: success on tcp_status_idle. Failure on timeout only; no retry, no abort.
  - timeout: timer == TIMEOUT_TICKS-1.
  - Success and failure/timeout in the same cycle: success wins.
  - On success: done pulses the next cycle, go to IDLE; retry_cnt holds its value.
- Connect/listen failure: go to ABORT.
- ABORT: tcp_disconnect high for one cycle; clear timer; go to ABORT_WAIT.
- ABORT_WAIT: wait for tcp_status_idle.
  - If retry_cnt < MAX_RETRY: increment retry_cnt, go to ISSUE.
  - Otherwise: fail pulses, go to IDLE.
  - Abort timeout (TIMEOUT_TICKS): fail pulses, go to IDLE.
- Strobes are mutually exclusive; at most one is high in any cycle.
- done and fail never assert together.
- Timer saturates only via state change; it never wraps inside WAIT.
- Reset mid-operation: immediate return to IDLE, outputs go to reset values, no disconnect is issued. The stack connection state is left to the stack's own reset.

Test Plan (bench: TIMEOUT_TICKS=100, MAX_RETRY=2, RTY_W=2):
1. Status idle, cmd op=0 at cycle 10 → tcp_connect_addr high in cycle 11 only. Model status goes connecting at 15, connected at 30 → done in cycle 31, retry_cnt=0, cmd_rdy=1 from 31.
2. op=1, model goes wait_dns then back to idle at cycle 20 → tcp_disconnect pulse, then tcp_connect_name reissued, retry_cnt=1. Second attempt connects → single done pulse.
3. op=0, model never leaves connecting → 3 connect_addr strobes, each followed by a tcp_disconnect after 100 cycles of WAIT. fail pulses once after the third abort completes; retry_cnt=2.
4. op=2 with status already connected → no strobe, fail at accept+1. op=3 while connected, idle 5 cycles later → done; no retry on a subsequent forced timeout case.
5. cmd_val held high during WAIT → ignored, cmd_rdy=0. Status goes connected and timer hits 99 in the same cycle → done, no fail.
6. Assert rst during ABORT_WAIT → all outputs at reset values in the same cycle (async). After release, cmd_rdy=1 and no strobes emitted.
